// File: rtl/hash_digest_pkg.sv
// hash_digest_pkg: shared widths, mode encodings, FSM state type and the per-mode digest length table.
//   WORD_W / DIN_W   : output word width and digest bus width
//   MODE_*           : algo_mode encodings {type, variant[2:0]}
//   state_t          : serializer FSM states
//   mode_len()       : algo_mode -> {word count, final-word keep, illegal}
package hash_digest_pkg;
   localparam int WORD_W = 64;
   localparam int DIN_W  = 1344;
   localparam logic [3:0] MODE_SHA256   = 4'b0000;
   localparam logic [3:0] MODE_SHA512   = 4'b0001;
   localparam logic [3:0] MODE_SHAKE128 = 4'b1000;
   localparam logic [3:0] MODE_SHAKE256 = 4'b1001;
   localparam logic [3:0] MODE_SHA3_256 = 4'b1010;
   localparam logic [3:0] MODE_SHA3_512 = 4'b1011;
   localparam logic [3:0] MODE_SHA3_224 = 4'b1100;
   localparam logic [3:0] MODE_SHA3_384 = 4'b1101;
   typedef enum logic {IDLE, SEND} state_t;
   typedef struct packed {
      logic [4:0] words;
      logic [7:0] keep;
      logic       illegal;
   } len_t;
   // SHAKE modes emit one full rate block; everything not listed is reserved.
   function automatic len_t mode_len(input logic [3:0] mode);
      case (mode)
         MODE_SHA256:   return '{5'd4,  8'hFF, 1'b0};
         MODE_SHA512:   return '{5'd8,  8'hFF, 1'b0};
         MODE_SHAKE128: return '{5'd21, 8'hFF, 1'b0};
         MODE_SHAKE256: return '{5'd17, 8'hFF, 1'b0};
         MODE_SHA3_256: return '{5'd4,  8'hFF, 1'b0};
         MODE_SHA3_512: return '{5'd8,  8'hFF, 1'b0};
         MODE_SHA3_224: return '{5'd4,  8'hF0, 1'b0};
         MODE_SHA3_384: return '{5'd6,  8'hFF, 1'b0};
         default:       return '{5'd0,  8'h00, 1'b1};
      endcase
   endfunction
endpackage

// File: rtl/digest_len_lut.sv
// digest_len_lut: combinational lookup of digest length for a hash mode.
//   algo_mode : {type, variant[2:0]}
//   words     : number of 64-bit output words
//   keep      : byte enables for the final word
//   illegal   : mode is reserved
module digest_len_lut
   import hash_digest_pkg::*;
(
   input  logic [3:0] algo_mode,
   output logic [4:0] words,
   output logic [7:0] keep,
   output logic       illegal
);
   always_comb {words, keep, illegal} = mode_len(algo_mode);
endmodule

// File: rtl/hash_digest_serializer.sv
// hash_digest_serializer: captures a wide MSB-aligned hash digest and streams it out as 64-bit words.
//   clk, rst             : clock and synchronous active-high reset
//   algo_mode            : hash mode, sampled only at capture
//   din, din_valid       : digest bus and its one-cycle qualifier
//   din_ready            : idle and able to capture
//   o_data/o_keep/o_last : output word, byte enables, final-word marker
//   o_valid, o_ready     : output handshake
//   drop                 : pulse, din_valid arrived while busy
//   err                  : pulse, capture refused for a reserved mode
module hash_digest_serializer #(
   parameter int WORD_W = hash_digest_pkg::WORD_W,
   parameter int DIN_W  = hash_digest_pkg::DIN_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        algo_mode,
   input  logic [DIN_W-1:0]  din,
   input  logic              din_valid,
   output logic              din_ready,
   output logic [WORD_W-1:0] o_data,
   output logic [7:0]        o_keep,
   output logic              o_last,
   output logic              o_valid,
   input  logic              o_ready,
   output logic              drop,
   output logic              err
);
   import hash_digest_pkg::*;
   state_t           state, state_n;
   logic [DIN_W-1:0] sh;
   logic [4:0]       cnt;
   logic [7:0]       keep_last;
   logic [4:0]       lut_words;
   logic [7:0]       lut_keep;
   logic             lut_illegal;
   logic             capture, hs;

   digest_len_lut u_lut (
      .algo_mode (algo_mode),
      .words     (lut_words),
      .keep      (lut_keep),
      .illegal   (lut_illegal)
   );

   always_ff @(posedge clk)
      state <= rst ? IDLE : state_n;

   always_comb begin
      din_ready = state == IDLE;
      o_valid   = state == SEND;
      o_last    = o_valid && cnt == 5'd1;
      o_keep    = !o_valid ? 8'h00 : o_last ? keep_last : 8'hFF;
      o_data    = sh[DIN_W-1 -: WORD_W];
      hs        = o_valid && o_ready;
      capture   = din_ready && din_valid && !lut_illegal;
      state_n   = capture ? SEND : (hs && o_last) ? IDLE : state;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sh        <= '0;
         cnt       <= '0;
         keep_last <= '0;
         drop      <= 1'b0;
         err       <= 1'b0;
      end else begin
         drop <= o_valid && din_valid;
         err  <= din_ready && din_valid && lut_illegal;
         if (capture) begin
            sh        <= din;
            cnt       <= lut_words;
            keep_last <= lut_keep;
         end else if (hs) begin
            sh  <= sh << WORD_W;
            cnt <= (cnt != 5'd0) ? cnt - 5'd1 : cnt;
         end
      end
   end
endmodule

// File: tb/tb_hash_digest_serializer.sv
// tb_hash_digest_serializer: self-checking bench with a byte-length reference model of the digest serializer.
module tb_hash_digest_serializer;
   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [3:0]    algo_mode = 4'b0000;
   logic [1343:0] din = '0;
   logic          din_valid = 1'b0;
   logic          din_ready;
   logic [63:0]   o_data;
   logic [7:0]    o_keep;
   logic          o_last;
   logic          o_valid;
   logic          o_ready = 1'b0;
   logic          drop;
   logic          err;
   int            n_assert = 0;
   int            n_fail = 0;
   logic [3:0]    legal [8] = '{4'b0000, 4'b0001, 4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1101};
   logic          rpat  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   hash_digest_serializer dut (
      .clk       (clk),
      .rst       (rst),
      .algo_mode (algo_mode),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .o_data    (o_data),
      .o_keep    (o_keep),
      .o_last    (o_last),
      .o_valid   (o_valid),
      .o_ready   (o_ready),
      .drop      (drop),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: digest length in bytes for each legal mode (SHAKE = one rate block).
   function automatic int digest_bytes(input logic [3:0] m);
      case (m)
         4'b0000: return 32;
         4'b0001: return 64;
         4'b1000: return 168;
         4'b1001: return 136;
         4'b1010: return 32;
         4'b1011: return 64;
         4'b1100: return 28;
         4'b1101: return 48;
         default: return 0;
      endcase
   endfunction

   function automatic logic [1343:0] rnd_din();
      logic [1343:0] r;
      for (int i = 0; i < 42; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   // Capture d in mode m, then drain it. pat=1 applies the 1,0,0,1 ready pattern;
   // inject>=0 pulses din_valid with a different digest in that SEND cycle.
   task automatic xfer(input logic [3:0] m, input logic [1343:0] d, input int pat, input int inject);
      int nb, nw, k, c;
      logic [7:0] lk;
      nb = digest_bytes(m);
      nw = (nb + 7) / 8;
      lk = 8'hFF << (8 * nw - nb);
      @(negedge clk);
      chk("din_ready_before_capture", {63'd0, din_ready}, 64'd1);
      algo_mode = m;
      din = d;
      din_valid = 1'b1;
      o_ready = 1'b0;
      @(negedge clk);
      din_valid = 1'b0;
      algo_mode = legal[$urandom_range(7)];
      din = rnd_din();
      k = 0;
      c = 0;
      while (k < nw && c < 400) begin
         if (c > 0) @(negedge clk);
         chk("o_valid", {63'd0, o_valid}, 64'd1);
         chk("o_data", o_data, d[1343 - 64*k -: 64]);
         chk("o_keep", {56'd0, o_keep}, {56'd0, (k == nw - 1) ? lk : 8'hFF});
         chk("o_last", {63'd0, o_last}, {63'd0, k == nw - 1});
         if (c == inject) begin
            din = rnd_din();
            din_valid = 1'b1;
         end else if (c == inject + 1) begin
            chk("drop_pulse", {63'd0, drop}, 64'd1);
            din_valid = 1'b0;
         end else begin
            chk("drop_quiet", {63'd0, drop}, 64'd0);
         end
         o_ready = (pat == 0) ? 1'b1 : rpat[c % 4];
         if (o_ready) k++;
         c++;
      end
      chk("words_within_budget", 64'(k), 64'(nw));
      @(negedge clk);
      o_ready = 1'b0;
      chk("o_valid_after_last", {63'd0, o_valid}, 64'd0);
      chk("din_ready_after_last", {63'd0, din_ready}, 64'd1);
   endtask

   initial begin
      logic [1343:0] d;
      repeat (2) @(negedge clk);
      chk("rst_o_valid", {63'd0, o_valid}, 64'd0);
      chk("rst_o_last", {63'd0, o_last}, 64'd0);
      chk("rst_o_keep", {56'd0, o_keep}, 64'd0);
      chk("rst_o_data", o_data, 64'd0);
      chk("rst_drop", {63'd0, drop}, 64'd0);
      chk("rst_err", {63'd0, err}, 64'd0);
      chk("rst_din_ready", {63'd0, din_ready}, 64'd1);
      rst = 1'b0;
      o_ready = 1'b1;
      @(negedge clk);
      chk("idle_ready_no_effect", {63'd0, o_valid}, 64'd0);
      o_ready = 1'b0;

      d = rnd_din();
      for (int i = 0; i < 32; i++) d[1343 - 8*i -: 8] = 8'(i);
      xfer(4'b0000, d, 0, -10);
      xfer(4'b1100, rnd_din(), 0, -10);
      xfer(4'b1000, rnd_din(), 1, -10);
      xfer(4'b0001, rnd_din(), 0, 2);

      foreach (legal[i]) if (i < 2) begin end
      for (int r = 0; r < 2; r++) begin
         @(negedge clk);
         algo_mode = (r == 0) ? 4'b1110 : 4'b0010;
         din = rnd_din();
         din_valid = 1'b1;
         @(negedge clk);
         din_valid = 1'b0;
         chk("err_pulse", {63'd0, err}, 64'd1);
         chk("err_o_valid", {63'd0, o_valid}, 64'd0);
         chk("err_din_ready", {63'd0, din_ready}, 64'd1);
         @(negedge clk);
         chk("err_cleared", {63'd0, err}, 64'd0);
         chk("err_still_idle", {63'd0, o_valid}, 64'd0);
      end

      d = rnd_din();
      @(negedge clk);
      algo_mode = 4'b1001;
      din = d;
      din_valid = 1'b1;
      @(negedge clk);
      din_valid = 1'b0;
      o_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         chk("abort_word", o_data, d[1343 - 64*k -: 64]);
         @(negedge clk);
      end
      chk("abort_word3_present", o_data, d[1343 - 192 -: 64]);
      rst = 1'b1;
      din_valid = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      din_valid = 1'b0;
      o_ready = 1'b0;
      chk("abort_o_valid", {63'd0, o_valid}, 64'd0);
      chk("abort_o_data", o_data, 64'd0);
      chk("abort_o_keep", {56'd0, o_keep}, 64'd0);
      chk("abort_din_ready", {63'd0, din_ready}, 64'd1);
      repeat (3) @(negedge clk);
      chk("abort_no_resume", {63'd0, o_valid}, 64'd0);
      xfer(4'b0000, rnd_din(), 0, -10);

      for (int r = 0; r < 6; r++)
         xfer(legal[$urandom_range(7)], rnd_din(), int'($urandom_range(1)), -10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/hash_digest_serializer.md
HASH_DIGEST_SERIALIZER -- requirements
Module: hash_digest_serializer

Interface
REQ-001 Parameters: WORD_W, default 64, output word width in bits; DIN_W, default 1344, digest bus width in bits. Only the defaults are supported.
REQ-002 clk  input  1  sole clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 algo_mode  input  4  {type, variant[2:0]}; type 0=SHA2 (variant[0]: 0=SHA-256, 1=SHA-512), type 1=SHAKE/SHA3 (000 SHAKE128, 001 SHAKE256, 010 SHA3-256, 011 SHA3-512, 100 SHA3-224, 101 SHA3-384).
REQ-005 din  input  1344  hash output from shake_sha2_top, digest MSB-aligned at din[1343].
REQ-006 din_valid  input  1  din qualifier, one-cycle pulse from the hash core.
REQ-007 din_ready  output  1  high when idle and able to capture.
REQ-008 o_data  output  64  current digest word.
REQ-009 o_keep  output  8  byte enables; bit 7 = o_data[63:56].
REQ-010 o_last  output  1  marks the final word of the digest.
REQ-011 o_valid  output  1  output word valid.
REQ-012 o_ready  input  1  downstream accept.
REQ-013 drop  output  1  one-cycle pulse: a din_valid was not captured.
REQ-014 err  output  1  one-cycle pulse: capture refused because of a reserved mode.

Function
REQ-015 FSM states: IDLE and SEND; reset state is IDLE.
REQ-016 IDLE: din_ready=1; if din_valid is high and the mode is legal, capture din, the word count and the last-word keep, then go to SEND on the next edge.
REQ-017 Word count / final keep by mode: SHA-256 4/FF; SHA-512 8/FF; SHAKE128 21/FF; SHAKE256 17/FF; SHA3-256 4/FF; SHA3-512 8/FF; SHA3-224 4/F0; SHA3-384 6/FF.
REQ-018 Reserved modes (SHAKE variant 110/111; SHA2 with variant[2:1]!=00): in IDLE with din_valid, no capture, err=1 for one cycle, FSM stays in IDLE.
REQ-019 algo_mode is sampled only at capture; later changes do not affect the transfer in progress.
REQ-020 Latency: capture edge at cycle N gives o_valid=1 in cycle N+1 with o_data=din[1343:1280].
REQ-021 Word k (0-based) = captured din[1343-64k -: 64]; implemented as a left shift by 64 on each handshake.
REQ-022 Handshake occurs when o_valid&&o_ready; o_data, o_keep and o_last hold stable while o_valid&&!o_ready.
REQ-023 o_keep=FF on all words except the last, which carries the per-mode keep; o_last=1 only on the last word.
REQ-024 Handshake on the last word: SEND->IDLE; o_valid=0 and din_ready=1 in the next cycle. A new capture in that same cycle is not allowed (one-cycle bubble).
REQ-025 din_valid while in SEND: ignored, drop=1 for one cycle; the current transfer is unaffected.
REQ-026 Internal word counter is 5 bits, decrements per handshake, and never wraps; the last word is detected when the count equals 1.
REQ-027 o_ready high in IDLE has no effect.

Reset
REQ-028 Reset values: o_valid=0, o_last=0, o_keep=00, o_data=0, drop=0, err=0, din_ready=1 (IDLE); counter and shift register cleared.
REQ-029 rst asserted during SEND aborts the transfer: o_valid=0 on the cycle after the rst edge, and no partial digest resumes afterwards.
REQ-030 rst has priority over din_valid and o_ready in the same cycle.

Structure
REQ-031 Shared package hash_digest_pkg holds: mode encoding constants, the FSM state typedef, WORD_W/DIN_W, and the per-mode word-count/keep table.
REQ-032 Sub-module digest_len_lut is combinational: algo_mode in; word count, final keep and illegal flag out. The rest is a single serializer FSM plus datapath.

Verification
REQ-033 SHA-256 (algo_mode=0000), din[1343:1088]=0x00..1F byte ramp, o_ready=1 -> 4 words: first 0x0001020304050607, last 0x18191A1B1C1D1E1F, o_last and o_keep=FF on word 4, o_valid at N+1.
REQ-034 SHA3-224 (algo_mode=1100) -> 4 words; word 4 has o_keep=F0 and o_last=1; din_ready high 1 cycle after the last handshake.
REQ-035 SHAKE128 (1000) with o_ready toggling 1,0,0,1 -> exactly 21 words in order, o_data stable during every stall, no word duplicated or skipped.
REQ-036 Second din_valid pulse during SEND of SHA-512 (0001) -> drop pulse, 8 words of the first digest only; algo_mode changed mid-transfer has no effect.
REQ-037 algo_mode=1110 with din_valid -> err=1 for one cycle, o_valid stays 0, din_ready stays 1.
REQ-038 rst pulse after word 3 of SHAKE256 (1001) -> o_valid=0 next cycle; a following SHA-256 capture outputs exactly 4 correct words.
